// File: rtl/main_mem_sequencer_pkg.sv
// rtl/main_mem_sequencer_pkg.sv - shared constants and types for the main-memory sequencer
package main_mem_sequencer_pkg;

    localparam int PHY_LEN        = 20;
    localparam int LINE_W         = 128;
    localparam int MEM_DEPTH_LOG2 = 12;
    localparam int MEM_LD_LATENCY = 5;
    localparam int MEM_SR_LATENCY = 5;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_WAIT,
        MS_RESP
    } mem_seq_state_t;

    typedef enum logic {
        OP_LOAD,
        OP_STORE
    } mem_op_t;

endpackage

// File: rtl/main_mem_sequencer_array.sv
// rtl/main_mem_sequencer_array.sv - line storage: async read, sync write with write-enable
module main_mem_array
    import main_mem_sequencer_pkg::*;
#(
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int WIDTH      = LINE_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Contents are deliberately not reset; only the sequencer decides when a write lands.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/main_mem_sequencer.sv
// rtl/main_mem_sequencer.sv - fixed-latency main memory sequencer; optional MAIN_MEM_STATS_EN adds load/store counters
module main_mem_sequencer
    import main_mem_sequencer_pkg::*;
#(
    parameter int PHY_W      = PHY_LEN,
    parameter int LINE_BITS  = LINE_W,
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int LD_LATENCY = MEM_LD_LATENCY,
    parameter int SR_LATENCY = MEM_SR_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PHY_W-1:0]     addr,
    input  logic                 ldp,
    input  logic                 srp,
    input  logic [LINE_BITS-1:0] srData,
    output logic                 ldr,
    output logic                 srr,
    output logic [LINE_BITS-1:0] ldData,
    output logic                 busy,
    output logic                 proto_err
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [31:0]          stat_loads,
    output logic [31:0]          stat_stores
`endif
);

    localparam int MAX_LAT = (LD_LATENCY > SR_LATENCY) ? LD_LATENCY : SR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] LD_START = (LD_LATENCY >= 2) ? CNT_W'(LD_LATENCY - 2) : '0;
    localparam logic [CNT_W-1:0] SR_START = (SR_LATENCY >= 2) ? CNT_W'(SR_LATENCY - 2) : '0;

    mem_seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [LINE_BITS-1:0]  data_q, data_d;
    mem_op_t               op_q, op_d;
    logic [LINE_BITS-1:0]  ld_data_q, ld_data_d;
    logic                  proto_err_q, proto_err_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic [LINE_BITS-1:0]  mem_wdata;
    logic [DEPTH_LOG2-1:0] mem_ridx;
    logic [LINE_BITS-1:0]  mem_rdata;

    logic [DEPTH_LOG2-1:0] bus_idx;
    logic                  lat_one;
    logic                  unused_addr;

    // Byte offset and bits above the array are dropped, so high addresses alias.
    assign bus_idx     = addr[DEPTH_LOG2+3:4];
    assign unused_addr = ^{addr[3:0], addr[PHY_W-1:DEPTH_LOG2+4]};
    assign lat_one     = srp ? (SR_LATENCY == 1) : (LD_LATENCY == 1);

    main_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (LINE_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_widx),
        .wdata (mem_wdata),
        .raddr (mem_ridx),
        .rdata (mem_rdata)
    );

    // Next-state, latency countdown and the single array access at the end of the wait.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        data_d      = data_q;
        op_d        = op_q;
        ld_data_d   = ld_data_q;
        proto_err_d = 1'b0;
        mem_we      = 1'b0;
        mem_widx    = idx_q;
        mem_wdata   = data_q;
        mem_ridx    = idx_q;
        case (state_q)
            MS_IDLE: begin
                if (srp || ldp) begin
                    idx_d       = bus_idx;
                    data_d      = srData;
                    op_d        = srp ? OP_STORE : OP_LOAD;
                    proto_err_d = srp && ldp;
                    cnt_d       = srp ? SR_START : LD_START;
                    if (lat_one) begin
                        // Single-cycle latency: the access uses the bus values directly.
                        state_d  = MS_RESP;
                        mem_widx = bus_idx;
                        mem_ridx = bus_idx;
                        if (srp) begin
                            mem_we    = 1'b1;
                            mem_wdata = srData;
                        end else begin
                            ld_data_d = mem_rdata;
                        end
                    end else begin
                        state_d = MS_WAIT;
                    end
                end
            end
            MS_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = MS_RESP;
                    if (op_q == OP_STORE) begin
                        mem_we = 1'b1;
                    end else begin
                        ld_data_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MS_RESP: begin
                state_d = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    // Sequencer state register; the latched request fields need no reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= MS_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            op_q        <= OP_LOAD;
            ld_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            op_q        <= op_d;
            ld_data_q   <= ld_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign ldr       = (state_q == MS_RESP) && (op_q == OP_LOAD);
    assign srr       = (state_q == MS_RESP) && (op_q == OP_STORE);
    assign busy      = (state_q != MS_IDLE);
    assign ldData    = ld_data_q;
    assign proto_err = proto_err_q;

`ifdef MAIN_MEM_STATS_EN
    logic [31:0] stat_loads_q, stat_loads_d;
    logic [31:0] stat_stores_q, stat_stores_d;

    // Saturating completion counters, bumped by the response pulses.
    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        if (ldr && (stat_loads_q != 32'hFFFF_FFFF)) begin
            stat_loads_d = stat_loads_q + 32'd1;
        end
        if (srr && (stat_stores_q != 32'hFFFF_FFFF)) begin
            stat_stores_d = stat_stores_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
`endif

endmodule

// File: tb/tb_main_mem_sequencer.sv
// tb/tb_main_mem_sequencer.sv - self-checking bench for main_mem_sequencer against a line-level memory model
`timescale 1ns/1ps
module tb_main_mem_sequencer;

    localparam int LAT_LD = 5;
    localparam int LAT_SR = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [19:0]  addr = '0;
    logic         ldp = 1'b0;
    logic         srp = 1'b0;
    logic [127:0] srData = '0;
    logic         ldr, srr, busy, proto_err;
    logic [127:0] ldData;
`ifdef MAIN_MEM_STATS_EN
    logic [31:0]  stat_loads, stat_stores;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] model_mem [int];
    logic [127:0] exp_ld = '0;
    bit           exp_ld_known = 1'b1;
    int           exp_loads = 0;
    int           exp_stores = 0;

    always #5 clk = ~clk;

    main_mem_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .ldp       (ldp),
        .srp       (srp),
        .srData    (srData),
        .ldr       (ldr),
        .srr       (srr),
        .ldData    (ldData),
        .busy      (busy),
        .proto_err (proto_err)
`ifdef MAIN_MEM_STATS_EN
        ,
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores)
`endif
    );

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Line number as the memory sees it: 16-byte lines, 4096 of them, wrapping.
    function automatic int line_of(input logic [19:0] a);
        return (int'(a) / 16) % 4096;
    endfunction

    task automatic check_stats();
`ifdef MAIN_MEM_STATS_EN
        check_vec("stat_loads", 128'(stat_loads), 128'(exp_loads));
        check_vec("stat_stores", 128'(stat_stores), 128'(exp_stores));
`endif
    endtask

    // One bus transaction, driven from just after a rising edge; request held until the response.
    task automatic do_req(input bit is_ld, input bit is_sr, input logic [19:0] a,
                          input logic [127:0] d, input bit scramble,
                          input logic [19:0] a2, input logic [127:0] d2);
        bit store;
        int exp_lat;
        int lat;
        int perr_cnt;
        int perr_at;
        bit seen;
        bit busy_ok;
        store   = is_sr;
        exp_lat = store ? LAT_SR : LAT_LD;
        addr = a; srData = d; ldp = is_ld; srp = is_sr;
        seen = 1'b0; lat = -1; perr_cnt = 0; perr_at = -1; busy_ok = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy !== (i >= 1)) busy_ok = 1'b0;
            if (proto_err === 1'b1) begin
                perr_cnt++;
                perr_at = i;
            end
            if (ldr === 1'b1 || srr === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
            if (scramble && i == 2) begin
                addr = a2;
                srData = d2;
            end
        end
        check_vec("latency", 128'(lat), 128'(exp_lat));
        check_vec("resp_kind", 128'({ldr, srr}), store ? 128'(2'b01) : 128'(2'b10));
        check_vec("busy", 128'(busy_ok), 128'(1));
        check_vec("proto_err_cnt", 128'(perr_cnt), 128'(is_ld && is_sr));
        if (is_ld && is_sr) check_vec("proto_err_at", 128'(perr_at), 128'(1));
        if (store) begin
            model_mem[line_of(a)] = d;
            exp_stores++;
        end else begin
            exp_loads++;
            if (model_mem.exists(line_of(a))) begin
                exp_ld = model_mem[line_of(a)];
                exp_ld_known = 1'b1;
                check_vec("ldData", ldData, exp_ld);
            end else begin
                exp_ld_known = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        ldp = 1'b0;
        srp = 1'b0;
        if (exp_ld_known) check_vec("ldData_hold", ldData, exp_ld);
        check_stats();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f, pat_g;
        int           srr_seen;
        pat_a = {4{32'hDEAD_BEEF}};
        pat_b = {4{32'hB0B0_B0B0}};
        pat_c = {4{32'hC0FF_EE00}};
        pat_d = {4{32'h1234_5678}};
        pat_e = {4{32'hE0E1_E2E3}};
        pat_f = {4{32'hF00D_F00D}};
        pat_g = {4{32'h6666_9999}};

        // Reset held with a pending load: everything quiet.
        rst = 1'b0; ldp = 1'b1; addr = 20'h00000;
        repeat (3) @(negedge clk);
        check_vec("rst_ldr", 128'(ldr), 128'(0));
        check_vec("rst_srr", 128'(srr), 128'(0));
        check_vec("rst_busy", 128'(busy), 128'(0));
        check_vec("rst_proto_err", 128'(proto_err), 128'(0));
        check_vec("rst_ldData", ldData, 128'(0));
        check_stats();
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_req(1, 0, 20'h00000, '0, 0, '0, '0);

        // Store then load the same line.
        do_req(0, 1, 20'h00040, pat_a, 0, '0, '0);
        do_req(1, 0, 20'h00040, '0, 0, '0, '0);

        // Aliasing above the array.
        do_req(0, 1, 20'h10040, pat_b, 0, '0, '0);
        do_req(1, 0, 20'h00040, '0, 0, '0, '0);

        // Bus changes after sampling are ignored.
        do_req(0, 1, 20'h00080, pat_c, 0, '0, '0);
        do_req(0, 1, 20'h00040, pat_d, 1, 20'h00080, pat_b);
        do_req(1, 0, 20'h00080, '0, 0, '0, '0);
        do_req(1, 0, 20'h00040, '0, 0, '0, '0);

        // Both requests at once: store wins, one proto_err pulse.
        do_req(1, 1, 20'h000C0, pat_e, 0, '0, '0);
        do_req(1, 0, 20'h000C0, '0, 0, '0, '0);

        // Store aborted by reset mid-wait never lands.
        do_req(0, 1, 20'h00100, pat_f, 0, '0, '0);
        addr = 20'h00100; srData = pat_g; srp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        srp = 1'b0;
        @(negedge clk);
        check_vec("abort_srr", 128'(srr), 128'(0));
        check_vec("abort_busy", 128'(busy), 128'(0));
        check_vec("abort_ldData", ldData, 128'(0));
        exp_ld = '0; exp_ld_known = 1'b1; exp_loads = 0; exp_stores = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        srr_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (srr === 1'b1) srr_seen++;
        end
        check_vec("abort_no_srr", 128'(srr_seen), 128'(0));
        check_stats();
        @(posedge clk);
        #1;
        do_req(1, 0, 20'h00100, '0, 0, '0, '0);

        // Randomized traffic over a handful of lines with random alias bits.
        for (int k = 0; k < 8; k++) begin
            do_req(0, 1, {4'($urandom), 12'(12'h200 + k), 4'($urandom)},
                   {$urandom, $urandom, $urandom, $urandom}, 0, '0, '0);
        end
        for (int n = 0; n < 40; n++) begin
            logic [19:0]  ra, ra2;
            logic [127:0] rd, rd2;
            bit           rl, rs, scr;
            ra  = {4'($urandom), 12'(12'h200 + $urandom_range(0, 7)), 4'($urandom)};
            ra2 = {4'($urandom), 12'(12'h200 + $urandom_range(0, 7)), 4'($urandom)};
            rd  = {$urandom, $urandom, $urandom, $urandom};
            rd2 = {$urandom, $urandom, $urandom, $urandom};
            rs  = ($urandom_range(0, 1) == 1);
            rl  = !rs || ($urandom_range(0, 7) == 0);
            scr = ($urandom_range(0, 3) == 0);
            do_req(rl, rs, ra, rd, scr, ra2, rd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
